comar_mask_prng: RTL and testbench

Fresh-mask source for COMAR first-order gadget layers. Expands a 31-bit seed through an unrolled LFSR and drives, every cycle, six fresh mask bits per gadget (`r[5:0]`) plus one shared `common_out` bit that is reused by every gadget in the layer. Sits directly upstream of the `*_COMAR` gadgets. Handles seeding, warm-up, and stall-hold so downstream gadgets see masks that are stable within a cycle and valid only after warm-up.

---
 rtl/comar_pkg.sv | 17 +
 rtl/comar_lfsr_step.sv | 19 +
 rtl/comar_mask_prng.sv | 92 +++++++++
 tb/tb_comar_mask_prng.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/comar_pkg.sv
// Shared constants and state encoding for the COMAR mask source: LFSR width,
// feedback taps, reset state and FSM state constants.
package comar_pkg;

  localparam int LFSR_W = 31;
  localparam int TAP_HI = 30;
  localparam int TAP_LO = 27;

  localparam logic [LFSR_W-1:0] LFSR_RESET = 31'h1;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_WARMUP = 2'd1;
  localparam state_t ST_RUN    = 2'd2;

endpackage

// File: rtl/comar_lfsr_step.sv
// Combinational K-step unroll of the 31-bit Fibonacci LFSR
// s' = {s[29:0], s[30]^s[27]}.
module comar_lfsr_step
  import comar_pkg::*;
#(
  parameter int K = 7
) (
  input  logic [LFSR_W-1:0] s_i,
  output logic [LFSR_W-1:0] s_o
);

  always_comb begin
    s_o = s_i;
    for (int i = 0; i < K; i++) begin
      s_o = {s_o[LFSR_W-2:0], s_o[TAP_HI] ^ s_o[TAP_LO]};
    end
  end

endmodule

// File: rtl/comar_mask_prng.sv
// Fresh-mask source for COMAR first-order gadgets: seeding, warm-up, stall-hold.
// Optional COMAR_MASK_PRNG_ZERO_LOCK_EN replaces an all-zero seed/state with 31'h1.
module comar_mask_prng
  import comar_pkg::*;
#(
  parameter int N_GADGETS = 1,
  parameter int WARMUP    = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [30:0]            seed_i,
  input  logic                   seed_valid_i,
  output logic                   seed_ready_o,
  input  logic                   enable_i,
  output logic                   rnd_valid_o,
  output logic [6*N_GADGETS-1:0] r_o,
  output logic                   common_o
);

  localparam int K      = 6*N_GADGETS + 1;
  localparam int WCNT_W = (WARMUP < 1) ? 1 : $clog2(WARMUP + 1);
  localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'((WARMUP == 0) ? 0 : WARMUP - 1);

  state_t              state_q, state_d;
  logic [LFSR_W-1:0]   s_q, s_d;
  logic [LFSR_W-1:0]   s_adv;
  logic [LFSR_W-1:0]   seed_load;
  logic [WCNT_W-1:0]   wcnt_q, wcnt_d;
  logic                seed_acc;

  comar_lfsr_step #(.K(K)) u_step (
    .s_i (s_q),
    .s_o (s_adv)
  );

`ifdef COMAR_MASK_PRNG_ZERO_LOCK_EN
  assign seed_load = (seed_i == '0) ? LFSR_RESET : seed_i;
`else
  assign seed_load = seed_i;
`endif

  assign seed_ready_o = (state_q != ST_WARMUP);
  assign seed_acc     = seed_valid_i & seed_ready_o;

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    wcnt_d  = wcnt_q;
    // A seed handshake outranks both warm-up and an enabled advance.
    if (seed_acc) begin
      s_d     = seed_load;
      wcnt_d  = '0;
      state_d = (WARMUP == 0) ? ST_RUN : ST_WARMUP;
    end else begin
      case (state_q)
        ST_IDLE: ;
        ST_WARMUP: begin
          s_d    = s_adv;
          wcnt_d = wcnt_q + 1'b1;
          if (wcnt_q == WCNT_LAST) state_d = ST_RUN;
        end
        ST_RUN: begin
`ifdef COMAR_MASK_PRNG_ZERO_LOCK_EN
          if (s_q == '0)    s_d = LFSR_RESET;
          else if (enable_i) s_d = s_adv;
`else
          if (enable_i) s_d = s_adv;
`endif
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      s_q     <= LFSR_RESET;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      wcnt_q  <= wcnt_d;
    end
  end

  // Outputs depend only on flops, so enable_i never reaches them combinationally.
  assign rnd_valid_o = (state_q == ST_RUN);
  assign r_o         = rnd_valid_o ? s_q[6*N_GADGETS-1:0] : '0;
  assign common_o    = rnd_valid_o & s_q[6*N_GADGETS];

endmodule

// File: tb/tb_comar_mask_prng.sv
// Bench for comar_mask_prng: two instances (N=1/WARMUP=0 and N=2/WARMUP=16)
// share stimulus and are checked every cycle against a bit-stream model.
module tb_comar_mask_prng;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [30:0] seed = '0;
  logic        sv = 1'b0;
  logic        en = 1'b0;

  logic        ready_a, valid_a, com_a;
  logic [5:0]  r_a;
  logic        ready_b, valid_b, com_b;
  logic [11:0] r_b;

  int n_vec = 0;
  int n_err = 0;

  int          m_phase [2];
  int          m_left  [2];
  logic [30:0] m_s     [2];
  int          m_w     [2];
  int          m_n     [2];

  always #5 clk = ~clk;

  comar_mask_prng #(.N_GADGETS(1), .WARMUP(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .seed_i(seed), .seed_valid_i(sv),
    .seed_ready_o(ready_a), .enable_i(en), .rnd_valid_o(valid_a),
    .r_o(r_a), .common_o(com_a)
  );

  comar_mask_prng #(.N_GADGETS(2), .WARMUP(16)) dut_b (
    .clk(clk), .rst_n(rst_n), .seed_i(seed), .seed_valid_i(sv),
    .seed_ready_o(ready_b), .enable_i(en), .rnd_valid_o(valid_b),
    .r_o(r_b), .common_o(com_b)
  );

  // The state is the newest 31 bits of the sequence x[t] = x[t-31] ^ x[t-28].
  function automatic logic [30:0] adv(input logic [30:0] s, input int k);
    bit q[$];
    logic [30:0] res;
    for (int i = 30; i >= 0; i--) q.push_back(s[i]);
    for (int j = 0; j < k; j++) q.push_back(q[q.size()-31] ^ q[q.size()-28]);
    for (int i = 0; i < 31; i++) res[i] = q[q.size()-1-i];
    return res;
  endfunction

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_phase[d] = 0;
      m_left[d]  = 0;
      m_s[d]     = 31'h1;
    end
  endtask

  task automatic model_edge(input int d);
    int k;
    k = 6*m_n[d] + 1;
    if (sv && m_phase[d] != 1) begin
`ifdef COMAR_MASK_PRNG_ZERO_LOCK_EN
      m_s[d] = (seed == 31'h0) ? 31'h1 : seed;
`else
      m_s[d] = seed;
`endif
      m_left[d]  = m_w[d];
      m_phase[d] = (m_w[d] == 0) ? 2 : 1;
    end else if (m_phase[d] == 1) begin
      m_s[d] = adv(m_s[d], k);
      m_left[d]--;
      if (m_left[d] == 0) m_phase[d] = 2;
    end else if (m_phase[d] == 2 && en) begin
      m_s[d] = adv(m_s[d], k);
    end
  endtask

  function automatic logic [31:0] exp_r(input int d);
    logic [31:0] mask;
    mask = (32'h1 << (6*m_n[d])) - 32'h1;
    return (m_phase[d] == 2) ? ({1'b0, m_s[d]} & mask) : 32'h0;
  endfunction

  function automatic logic [31:0] exp_c(input int d);
    return (m_phase[d] == 2) ? {31'h0, m_s[d][6*m_n[d]]} : 32'h0;
  endfunction

  task automatic check_all();
    cmp("a_valid", {31'h0, valid_a}, (m_phase[0] == 2) ? 32'h1 : 32'h0);
    cmp("a_ready", {31'h0, ready_a}, (m_phase[0] != 1) ? 32'h1 : 32'h0);
    cmp("a_r",     {26'h0, r_a},     exp_r(0));
    cmp("a_common",{31'h0, com_a},   exp_c(0));
    cmp("b_valid", {31'h0, valid_b}, (m_phase[1] == 2) ? 32'h1 : 32'h0);
    cmp("b_ready", {31'h0, ready_b}, (m_phase[1] != 1) ? 32'h1 : 32'h0);
    cmp("b_r",     {20'h0, r_b},     exp_r(1));
    cmp("b_common",{31'h0, com_b},   exp_c(1));
  endtask

  task automatic step();
    @(posedge clk);
    if (rst_n) begin
      model_edge(0);
      model_edge(1);
    end
    @(negedge clk);
    check_all();
  endtask

  initial begin
    logic [5:0]  hold_ra;
    logic [11:0] hold_rb;
    logic        hold_ca, hold_cb;

    m_w[0] = 0;  m_n[0] = 1;
    m_w[1] = 16; m_n[1] = 2;
    model_reset();

    // Reset state, checked before any clock edge.
    #1 rst_n = 1'b0;
    #1 check_all();
    @(negedge clk);
    check_all();
    rst_n = 1'b1;

    cmp("pin_adv_7f",  adv(31'h7F, 7),        32'h00003F80);
    cmp("pin_adv_1",   adv(31'h1, 7),         32'h00000080);
    cmp("pin_tap30",   adv(31'h40000000, 1),  32'h00000001);
    cmp("pin_tap27",   adv(31'h08000000, 1),  32'h10000001);

    // Basic seed: accepting edge is edge 1.
    seed = 31'h7F; sv = 1'b1; en = 1'b0;
    step();
    cmp("a_first_r",     {26'h0, r_a},   32'h3F);
    cmp("a_first_c",     {31'h0, com_a}, 32'h1);
    cmp("a_first_valid", {31'h0, valid_a}, 32'h1);
    cmp("b_warm_ready",  {31'h0, ready_b}, 32'h0);

    sv = 1'b0; en = 1'b1;
    step();
    cmp("a_adv_r", {26'h0, r_a},   32'h0);
    cmp("a_adv_c", {31'h0, com_a}, 32'h0);

    // Remaining warm-up edges; the seed at edge 8 reseeds dut_a but dut_b ignores it.
    for (int e = 3; e <= 16; e++) begin
      en   = e[0];
      sv   = (e == 8);
      seed = 31'h5555;
      step();
      cmp("b_warm_valid", {31'h0, valid_b}, 32'h0);
    end
    sv = 1'b0; en = 1'b0;
    step();
    cmp("b_first_valid", {31'h0, valid_b}, 32'h1);

    // Stall hold.
    hold_ra = r_a; hold_rb = r_b; hold_ca = com_a; hold_cb = com_b;
    repeat (5) begin
      step();
      cmp("a_stall_r", {26'h0, r_a},   {26'h0, hold_ra});
      cmp("b_stall_r", {20'h0, r_b},   {20'h0, hold_rb});
      cmp("a_stall_c", {31'h0, com_a}, {31'h0, hold_ca});
      cmp("b_stall_c", {31'h0, com_b}, {31'h0, hold_cb});
    end
    en = 1'b1;
    repeat (3) step();
    en = 1'b0; step();
    en = 1'b1; step();

    // Seed and enable together: seed wins.
    seed = 31'h12345678; sv = 1'b1; en = 1'b1;
    step();
    cmp("a_reseed_r",     {26'h0, r_a},     32'h38);
    cmp("a_reseed_c",     {31'h0, com_a},   32'h1);
    cmp("b_reseed_valid", {31'h0, valid_b}, 32'h0);
    sv = 1'b0;

    // Asynchronous reset in the middle of dut_b's warm-up.
    repeat (3) step();
    #2 rst_n = 1'b0;
    #1 model_reset();
    check_all();
    cmp("b_async_ready", {31'h0, ready_b}, 32'h1);
    cmp("b_async_r",     {20'h0, r_b},     32'h0);
    @(negedge clk);
    check_all();
    step();
    rst_n = 1'b1;

    // Zero seed.
    seed = 31'h0; sv = 1'b1; en = 1'b0;
    step();
`ifdef COMAR_MASK_PRNG_ZERO_LOCK_EN
    cmp("a_zero_r", {26'h0, r_a}, 32'h01);
`else
    cmp("a_zero_r", {26'h0, r_a}, 32'h00);
`endif
    sv = 1'b0; en = 1'b1;
    repeat (20) step();
`ifndef COMAR_MASK_PRNG_ZERO_LOCK_EN
    cmp("a_zero_hold", {26'h0, r_a}, 32'h0);
    cmp("b_zero_hold", {20'h0, r_b}, 32'h0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
